adc_sdata_tx: RTL and testbench

ADC_SDATA_TX -- requirements
Module: adc_sdata_tx

---
 rtl/adc_sdata_tx.sv | 185 ++++++++++++++++++
 tb/tb_adc_sdata_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sdata_tx.sv
// rtl/adc_sdata_tx.sv - two-lane serial ADC frame transmitter driven by ad_cs; holding register feeds per-lane shift registers.
// Optional ADC_SDATA_TX_PATTERN_EN replaces sample inputs with an internal counting pattern.
module adc_sdata_tx #(
    parameter int SAMPLE_W  = 12,
    parameter int LEAD_BITS = 2,
    parameter int FRAME_LEN = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ad_cs,
    output logic [1:0]          ad_sdata,
    input  logic [SAMPLE_W-1:0] sample_0,
    input  logic [SAMPLE_W-1:0] sample_1,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                underrun,
    output logic                frame_done
);

    localparam int K_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [K_W-1:0]      r_k;
    logic [K_W-1:0]      w_k_nxt;
    logic                r_cs_q;
    logic                r_cs_armed;
    logic [SAMPLE_W-1:0] r_sh0;
    logic [SAMPLE_W-1:0] r_sh1;
    logic [SAMPLE_W-1:0] w_sh0_nxt;
    logic [SAMPLE_W-1:0] w_sh1_nxt;
    logic                w_start;
    logic                w_underrun_nxt;
    logic                r_underrun;
    logic                r_frame_done;
    logic [1:0]          r_sdata;
    logic [1:0]          w_sdata_nxt;
    logic [31:0]         w_kx;

    // After reset, a low ad_cs is not a frame start until ad_cs has been seen high.
    assign w_start = (r_state == S_IDLE) && r_cs_q && r_cs_armed && !ad_cs;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SHIFT;
                    w_k_nxt     = '0;
                end
            end
            S_SHIFT: begin
                if (ad_cs) begin
                    w_state_nxt = S_IDLE;
                    w_k_nxt     = '0;
                end else if (r_k == K_LAST) begin
                    w_state_nxt = S_DONE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_DONE: begin
                if (ad_cs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

`ifdef ADC_SDATA_TX_PATTERN_EN
    logic [SAMPLE_W-1:0] r_pat;

    assign sample_ready = 1'b1;

    always_comb begin
        w_sh0_nxt      = r_sh0;
        w_sh1_nxt      = r_sh1;
        w_underrun_nxt = 1'b0;
        if (w_start) begin
            w_sh0_nxt = r_pat;
            w_sh1_nxt = ~r_pat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pat <= '0;
        end else if (w_start) begin
            r_pat <= r_pat + 1'b1;
        end
    end
`else
    logic                r_full;
    logic [SAMPLE_W-1:0] r_h0;
    logic [SAMPLE_W-1:0] r_h1;
    logic                w_load;

    assign sample_ready = reset_n && !r_full;
    assign w_load       = sample_valid && sample_ready;

    // An empty holding register at frame start repeats the previous samples.
    always_comb begin
        w_sh0_nxt      = r_sh0;
        w_sh1_nxt      = r_sh1;
        w_underrun_nxt = w_start && !r_full;
        if (w_start && r_full) begin
            w_sh0_nxt = r_h0;
            w_sh1_nxt = r_h1;
        end
    end

    // A load coinciding with an underrun start is kept for the next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_h0   <= '0;
            r_h1   <= '0;
        end else if (w_start && r_full) begin
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_h0   <= sample_0;
            r_h1   <= sample_1;
        end
    end
`endif

    assign w_kx = 32'(w_k_nxt);

    // Output is computed from next-cycle state so the bit lands in the same cycle as its k.
    always_comb begin
        w_sdata_nxt = 2'b00;
        if (w_state_nxt == S_SHIFT) begin
            for (int b = 0; b < SAMPLE_W; b++) begin
                if (w_kx == 32'(LEAD_BITS + SAMPLE_W - 1 - b)) begin
                    w_sdata_nxt = {w_sh1_nxt[b], w_sh0_nxt[b]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_cs_q       <= 1'b1;
            r_cs_armed   <= 1'b0;
            r_sh0        <= '0;
            r_sh1        <= '0;
            r_sdata      <= 2'b00;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_cs_q       <= ad_cs;
            if (ad_cs) begin
                r_cs_armed <= 1'b1;
            end
            r_sh0        <= w_sh0_nxt;
            r_sh1        <= w_sh1_nxt;
            r_sdata      <= w_sdata_nxt;
            r_underrun   <= w_underrun_nxt;
            r_frame_done <= (w_state_nxt == S_SHIFT) && (w_k_nxt == K_LAST);
        end
    end

    assign ad_sdata   = r_sdata;
    assign underrun   = r_underrun;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_adc_sdata_tx.sv
// tb/tb_adc_sdata_tx.sv - randomized self-checking bench for adc_sdata_tx against a frame-level model.
module tb_adc_sdata_tx;

    localparam int SW = 12;
    localparam int LB = 2;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ad_cs = 1'b1;
    logic [1:0]    ad_sdata;
    logic [SW-1:0] sample_0 = '0;
    logic [SW-1:0] sample_1 = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          underrun;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    bit            m_full;
    logic [SW-1:0] m_h0, m_h1, m_l0, m_l1, m_pat;
    logic [FL-1:0] cap0, cap1;

    adc_sdata_tx #(.SAMPLE_W(SW), .LEAD_BITS(LB), .FRAME_LEN(FL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ad_cs       (ad_cs),
        .ad_sdata    (ad_sdata),
        .sample_0    (sample_0),
        .sample_1    (sample_1),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .underrun    (underrun),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_full = 1'b0;
        m_h0 = '0; m_h1 = '0; m_l0 = '0; m_l1 = '0; m_pat = '0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        ad_cs   = 1'b1;
        model_reset();
        repeat (3) step();
        n_checks++;
        if ({ad_sdata, frame_done, underrun, sample_ready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_state: got %b, expected 00000", {ad_sdata, frame_done, underrun, sample_ready});
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if ({ad_sdata, frame_done, underrun, sample_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_release: got %b, expected 00001", {ad_sdata, frame_done, underrun, sample_ready});
        end
    endtask

    task automatic load(input logic [SW-1:0] a, input logic [SW-1:0] b);
        n_checks++;
        if (sample_ready !== !m_full) begin
            n_fail++;
            $display("FAIL load_ready: got %b, expected %b", sample_ready, !m_full);
        end
        sample_0 = a; sample_1 = b; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        if (!m_full) begin
            m_h0 = a; m_h1 = b; m_full = 1'b1;
        end
        n_checks++;
        if (sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_blocks_ready: got %b, expected 0", sample_ready);
        end
    endtask

    // kind: 0 complete frame, 1 ad_cs abort at at_k, 2 reset at at_k
    task automatic run_frame(input int kind, input int at_k, input bit ld,
                             input logic [SW-1:0] n0, input logic [SW-1:0] n1, input string name);
        logic [SW-1:0] t0, t1;
        bit            ur;
        bit            q0[$];
        bit            q1[$];
        logic [4:0]    exp_v;
        bit            rdy;
        int            stop_j;
`ifdef ADC_SDATA_TX_PATTERN_EN
        t0 = m_pat; t1 = ~m_pat; m_pat = m_pat + 1'b1; ur = 1'b0;
`else
        if (m_full) begin
            t0 = m_h0; t1 = m_h1; m_full = 1'b0; ur = 1'b0;
        end else begin
            t0 = m_l0; t1 = m_l1; ur = 1'b1;
            if (ld) begin
                m_h0 = n0; m_h1 = n1; m_full = 1'b1;
            end
        end
`endif
        m_l0 = t0; m_l1 = t1;
        for (int i = 0; i < LB; i++) begin q0.push_back(1'b0); q1.push_back(1'b0); end
        for (int b = SW - 1; b >= 0; b--) begin q0.push_back(t0[b]); q1.push_back(t1[b]); end
        while (q0.size() < FL) begin q0.push_back(1'b0); q1.push_back(1'b0); end

        ad_cs = 1'b0;
        if (ld) begin
            sample_0 = n0; sample_1 = n1; sample_valid = 1'b1;
        end
        stop_j = FL;
        cap0 = '0; cap1 = '0;
        for (int j = 0; j < FL; j++) begin
            step();
            sample_valid = 1'b0;
`ifdef ADC_SDATA_TX_PATTERN_EN
            rdy = 1'b1;
`else
            rdy = !m_full;
`endif
            exp_v = {q1[j], q0[j], (j == FL - 1), (j == 0) && ur, rdy};
            cap0 = {cap0[FL-2:0], ad_sdata[0]};
            cap1 = {cap1[FL-2:0], ad_sdata[1]};
            n_checks++;
            if ({ad_sdata, frame_done, underrun, sample_ready} !== exp_v) begin
                n_fail++;
                $display("FAIL %s k=%0d: got sdata/done/ur/rdy=%b, expected %b", name, j,
                         {ad_sdata, frame_done, underrun, sample_ready}, exp_v);
            end
            if (kind != 0 && j == at_k) begin
                stop_j = j;
                break;
            end
        end

        if (kind == 2) begin
            reset_n = 1'b0;
            step();
            model_reset();
            n_checks++;
            if ({ad_sdata, frame_done, underrun, sample_ready} !== 5'b00000) begin
                n_fail++;
                $display("FAIL %s in_reset: got %b, expected 00000", name, {ad_sdata, frame_done, underrun, sample_ready});
            end
            reset_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                n_checks++;
                if ({ad_sdata, frame_done, underrun} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL %s no_restart c=%0d: got %b, expected 0000", name, i, {ad_sdata, frame_done, underrun});
                end
            end
        end else begin
            if (kind == 1) ad_cs = 1'b1;
            step();
            n_checks++;
            if ({ad_sdata, frame_done, underrun} !== 4'b0000) begin
                n_fail++;
                $display("FAIL %s after_k%0d: got %b, expected 0000", name, stop_j, {ad_sdata, frame_done, underrun});
            end
        end
        ad_cs = 1'b1;
        step();
        step();
    endtask

`ifdef ADC_SDATA_TX_PATTERN_EN
    task automatic test_pattern;
        logic [FL-1:0] e0 [3];
        logic [FL-1:0] e1 [3];
        e0[0] = 16'h0000; e0[1] = 16'h0004; e0[2] = 16'h0008;
        e1[0] = 16'h3FFC; e1[1] = 16'h3FF8; e1[2] = 16'h3FF4;
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 1'b0, '0, '0, "pattern");
            n_checks++;
            if ({cap1, cap0} !== {e1[f], e0[f]}) begin
                n_fail++;
                $display("FAIL pattern_words f=%0d: got %h/%h, expected %h/%h", f, cap0, cap1, e0[f], e1[f]);
            end
        end
    endtask
`else
    task automatic test_basic;
        load(12'hA5C, 12'h3F0);
        run_frame(0, 0, 1'b0, '0, '0, "basic");
        n_checks++;
        if ({cap1, cap0} !== {16'h0FC0, 16'h2970}) begin
            n_fail++;
            $display("FAIL basic_words: got %h/%h, expected 2970/0fc0", cap0, cap1);
        end
    endtask

    task automatic test_underrun;
        run_frame(0, 0, 1'b0, '0, '0, "underrun");
        n_checks++;
        if ({cap1, cap0} !== {16'h0FC0, 16'h2970}) begin
            n_fail++;
            $display("FAIL underrun_words: got %h/%h, expected 2970/0fc0", cap0, cap1);
        end
    endtask

    task automatic test_abort;
        load(SW'($urandom), SW'($urandom));
        run_frame(1, 5, 1'b0, '0, '0, "abort");
        load(SW'($urandom), SW'($urandom));
        run_frame(0, 0, 1'b0, '0, '0, "after_abort");
    endtask

    task automatic test_simul_load;
        run_frame(0, 0, 1'b1, SW'($urandom), SW'($urandom), "simul_start");
        run_frame(0, 0, 1'b0, '0, '0, "simul_next");
    endtask

    task automatic test_reset_mid;
        load(SW'($urandom), SW'($urandom));
        run_frame(2, 8, 1'b0, '0, '0, "reset_mid");
        run_frame(0, 0, 1'b0, '0, '0, "post_reset");
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) load(SW'($urandom), SW'($urandom));
            run_frame(0, 0, 1'($urandom_range(0, 1)), SW'($urandom), SW'($urandom), "random");
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef ADC_SDATA_TX_PATTERN_EN
        test_pattern();
`else
        test_basic();
        test_underrun();
        test_abort();
        test_simul_load();
        test_reset_mid();
        test_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
